// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame mailbox.
// Contents:
//   state_e            - frame engine states (IDLE, SHIFT, CHECK)
//   FRAME_CNT_W        - width of the good-frame counter
//   WDT_CYCLES_DEFAULT - default watchdog timeout in CLK cycles
package spi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int unsigned FRAME_CNT_W        = 16;
  localparam int unsigned WDT_CYCLES_DEFAULT = 5000000;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with edge pulses.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   din        - raw pin
//   dout       - synchronised level (last synchroniser stage)
//   rise, fall - one-cycle pulses when the synchronised level changes
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   prev_d, prev_q;

  // Next-state for the synchroniser chain and the edge-history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edges compare the last synchronised stage with one further flop.
  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_mailbox.sv
// SPI slave (mode 0) frame engine, oversampled in the CLK domain.
// Shifts in one FRAME_BITS frame (bit 0 first) while shifting out a snapshot
// of TX_DATA taken at CS_N fall. The frame is committed to RX_DATA only when
// exactly FRAME_BITS bits were clocked; a watchdog forces RX_DATA to
// SAFE_VALUE when good frames stop arriving.
// Ports:
//   CLK, RESET_N        - system clock, asynchronous active-low reset
//   SPI_SCLK/CS_N/MOSI  - SPI pins from the host (asynchronous)
//   SPI_MISO            - serial data to the host (registered)
//   TX_DATA             - frame to send, sampled at CS_N fall
//   RX_DATA             - last committed frame
//   RX_VALID, FRAME_ERR - one-cycle pulses on commit / discarded frame
//   WDT_EN, WDT_EXPIRED - watchdog enable, sticky expiry flag
//   FRAME_CNT           - count of good frames, wrapping
module spi_frame_mailbox
  import spi_frame_pkg::*;
#(
  parameter int unsigned           FRAME_BITS  = 256,
  parameter logic [FRAME_BITS-1:0] SAFE_VALUE  = {FRAME_BITS{1'b0}},
  parameter int unsigned           WDT_CYCLES  = WDT_CYCLES_DEFAULT,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   SPI_SCLK,
  input  logic                   SPI_CS_N,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  input  logic [FRAME_BITS-1:0]  TX_DATA,
  output logic [FRAME_BITS-1:0]  RX_DATA,
  output logic                   RX_VALID,
  output logic                   FRAME_ERR,
  input  logic                   WDT_EN,
  output logic                   WDT_EXPIRED,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

  // Bit counter must reach FRAME_BITS+1 to flag an overrun.
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam int unsigned IDX_W = $clog2(FRAME_BITS);
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES);

  localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]       CNT_OVER = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [WDT_W-1:0]       WDT_PRE  = WDT_W'(WDT_CYCLES - 2);
  localparam logic [WDT_W-1:0]       WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [WDT_W-1:0]       WDT_ONE  = WDT_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FCNT_ONE = FRAME_CNT_W'(1);

  logic sclk_rise_s, sclk_fall_s, sclk_lvl_s;
  logic cs_rise_s, cs_fall_s, cs_lvl_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic unused_sync_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(CLK), .rst_n(RESET_N), .din(SPI_SCLK),
    .dout(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(CLK), .rst_n(RESET_N), .din(SPI_CS_N),
    .dout(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst_n(RESET_N), .din(SPI_MOSI),
    .dout(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Only edges of SCLK/CS_N and the level of MOSI are needed.
  assign unused_sync_s = ^{sclk_lvl_s, cs_lvl_s, mosi_rise_s, mosi_fall_s};

  state_e                 state_d, state_q;
  logic [FRAME_BITS-1:0]  tx_shift_d, tx_shift_q;
  logic [FRAME_BITS-1:0]  rx_shift_d, rx_shift_q;
  logic [CNT_W-1:0]       bit_cnt_d, bit_cnt_q;
  logic                   miso_d, miso_q;
  logic [FRAME_BITS-1:0]  rx_data_d, rx_data_q;
  logic                   rx_valid_d, rx_valid_q;
  logic                   frame_err_d, frame_err_q;
  logic [WDT_W-1:0]       wdt_cnt_d, wdt_cnt_q;
  logic                   wdt_expired_d, wdt_expired_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic                   start_s, commit_s;
  logic [IDX_W-1:0]       bit_idx_s;

  assign bit_idx_s = bit_cnt_q[IDX_W-1:0];

  // Frame FSM, shift datapath and watchdog next-state logic.
  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    wdt_cnt_d     = wdt_cnt_q;
    wdt_expired_d = wdt_expired_q;
    frame_cnt_d   = frame_cnt_q;
    start_s       = 1'b0;
    commit_s      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          state_d = CHECK;
        end else if (sclk_rise_s) begin
          if (bit_cnt_q < CNT_FULL) begin
            rx_shift_d[bit_idx_s] = mosi_s;
          end else begin
            rx_shift_d = rx_shift_q;
          end
          // Saturate one past full so an overrun stays distinguishable.
          if (bit_cnt_q != CNT_OVER) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_q < CNT_FULL) begin
            miso_d = tx_shift_q[bit_idx_s];
          end else begin
            miso_d = 1'b0;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      CHECK: begin
        state_d = IDLE;
        miso_d  = 1'b0;
        if (bit_cnt_q == CNT_FULL) begin
          commit_s = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        // A new frame starting right behind the previous one is not lost.
        if (cs_fall_s) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase

    if (start_s) begin
      state_d    = SHIFT;
      tx_shift_d = TX_DATA;
      bit_cnt_d  = {CNT_W{1'b0}};
      miso_d     = TX_DATA[0];
    end else begin
      tx_shift_d = tx_shift_d;
    end

    // A commit takes priority over a coincident watchdog expiry.
    if (commit_s) begin
      rx_data_d     = rx_shift_q;
      rx_valid_d    = 1'b1;
      frame_cnt_d   = frame_cnt_q + FCNT_ONE;
      wdt_cnt_d     = {WDT_W{1'b0}};
      wdt_expired_d = 1'b0;
    end else if (WDT_EN) begin
      // Expire on the cycle the counter lands on WDT_CYCLES-1, then hold
      // there and keep re-forcing RX_DATA until the next good commit.
      if (wdt_cnt_q >= WDT_PRE) begin
        wdt_cnt_d     = WDT_LAST;
        wdt_expired_d = 1'b1;
        rx_data_d     = SAFE_VALUE;
      end else begin
        wdt_cnt_d = wdt_cnt_q + WDT_ONE;
      end
    end else begin
      wdt_cnt_d = {WDT_W{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      tx_shift_q    <= {FRAME_BITS{1'b0}};
      rx_shift_q    <= {FRAME_BITS{1'b0}};
      bit_cnt_q     <= {CNT_W{1'b0}};
      miso_q        <= 1'b0;
      rx_data_q     <= SAFE_VALUE;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      wdt_cnt_q     <= {WDT_W{1'b0}};
      wdt_expired_q <= 1'b0;
      frame_cnt_q   <= {FRAME_CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      wdt_cnt_q     <= wdt_cnt_d;
      wdt_expired_q <= wdt_expired_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign WDT_EXPIRED = wdt_expired_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: doc/spi_frame_mailbox.md
Name: spi_frame_mailbox

Overview:
Parametrised SPI slave frame engine, oversampled in the system clock domain. It shifts in one FRAME_BITS-wide frame from the host and simultaneously shifts out a snapshot of TX_DATA. The received frame is committed atomically to RX_DATA only when the bit count is exact. A watchdog forces RX_DATA to a safe value when valid frames stop arriving. It sits between the SPI pins and the frame-to-signal mapping blocks.

Parameters:
FRAME_BITS, 256, bits per frame (>= 8)
SAFE_VALUE, {FRAME_BITS{1'b0}}, value loaded into RX_DATA on reset and on watchdog expiry
WDT_CYCLES, 5000000, CLK cycles without a good frame before expiry (>= 2)
SYNC_STAGES, 2, synchroniser depth for SCLK/CS_N/MOSI (>= 2)

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous reset, active low
SPI_SCLK  in  1  SPI clock, mode 0, at most CLK/8
SPI_CS_N  in  1  chip select, active low
SPI_MOSI  in  1  serial data in
SPI_MISO  out  1  serial data out
TX_DATA  in  FRAME_BITS  frame to send; sampled at CS_N fall
RX_DATA  out  FRAME_BITS  last committed frame
RX_VALID  out  1  one-cycle pulse on commit
FRAME_ERR  out  1  one-cycle pulse on a discarded frame
WDT_EN  in  1  watchdog enable
WDT_EXPIRED  out  1  sticky expiry flag
FRAME_CNT  out  16  count of good frames, wraps at 0xFFFF -> 0

Behaviour:
- Interface: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset values:
  - RX_DATA = SAFE_VALUE.
  - SPI_MISO, RX_VALID, FRAME_ERR, WDT_EXPIRED = 0; FRAME_CNT = 0.
  - Shift register, bit counter and watchdog counter = 0.
  - Synchronisers reset to SCLK=0, CS_N=1, MOSI=0.
- Edge detection: the SPI inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last synced stage with one further flop.
- States:
  - IDLE: CS_N high. SPI_MISO = 0. No bit counting.
  - IDLE -> SHIFT on synced CS_N fall:
    - load tx_shift <= TX_DATA;
    - bit_cnt <= 0;
    - SPI_MISO <= TX_DATA[0] (bit 0 goes out first; bit 0 is also the first bit received).
  - SHIFT, synced SCLK rise:
    - rx_shift[bit_cnt] <= synced MOSI;
    - bit_cnt increments, saturating at FRAME_BITS+1.
  - SHIFT, synced SCLK fall:
    - SPI_MISO <= tx_shift[bit_cnt] while bit_cnt < FRAME_BITS, else 0.
  - SHIFT -> CHECK on synced CS_N rise.
  - CHECK (one cycle), then always -> IDLE:
    - bit_cnt == FRAME_BITS: RX_DATA <= rx_shift, RX_VALID = 1 for one cycle, FRAME_CNT += 1, watchdog counter cleared, WDT_EXPIRED cleared.
    - any other count (short frame, or overrun saturated at FRAME_BITS+1): RX_DATA unchanged, FRAME_ERR = 1 for one cycle.
- Latency: RX_VALID and the new RX_DATA appear together, SYNC_STAGES+2 CLK cycles after the CS_N rise at the pin.
- SCLK edges while CS_N is high are ignored.
- A CS_N fall seen in CHECK is honoured on the next cycle; SPI_MISO setup must still meet CLK/8 timing.
- Watchdog:
  - WDT_EN = 0: counter held at 0; WDT_EXPIRED keeps its value.
  - WDT_EN = 1: counter increments every cycle.
  - When the counter reaches WDT_CYCLES-1: RX_DATA <= SAFE_VALUE, WDT_EXPIRED <= 1, counter holds.
  - RX_DATA is then re-forced every cycle until a good commit.
  - Commit and expiry in the same cycle: the commit wins, and WDT_EXPIRED stays 0.
- Reset mid-frame: all state returns to its reset value immediately. The partial frame is lost and no FRAME_ERR is raised.

Decomposition:
- Shared package spi_frame_pkg: state enum (IDLE, SHIFT, CHECK), FRAME_CNT width constant (16), default WDT_CYCLES constant.
- Sub-module spi_sync_edge, instantiated per input: synchroniser plus rise/fall pulse outputs, parameter SYNC_STAGES.

Test Plan:
- FRAME_BITS=16, send 0xA5C3 with bit 0 first; TX_DATA=0x1234 -> RX_DATA=0xA5C3, one RX_VALID pulse, FRAME_CNT=1, MISO bit sequence equals 0x1234 bit 0 first.
- Send 15 bits of 0xFFFF after a good frame of 0x00FF -> FRAME_ERR pulse, RX_DATA stays 0x00FF, FRAME_CNT unchanged.
- Send 17 bits -> FRAME_ERR pulse, no RX_VALID, RX_DATA unchanged.
- WDT_CYCLES=100, WDT_EN=1, no frames -> at cycle 99 RX_DATA=SAFE_VALUE and WDT_EXPIRED=1; a good frame 0x0001 clears WDT_EXPIRED, RX_DATA=0x0001.
- Force the commit onto the expiry cycle -> RX_DATA = the committed frame, WDT_EXPIRED=0.
- Assert RESET_N low after 8 bits -> all outputs at reset values; a following full frame commits correctly with FRAME_CNT=1.
- Extra check: preload FRAME_CNT=0xFFFF and send a good frame -> FRAME_CNT=0.
